// File: rtl/enc_pkg.sv
// Shared types and sizes for the sequential 16-to-4 encoder.
// Scan direction is chosen at build time by ENC_MSB_FIRST_EN (see prio_enc16).
package enc_pkg;

   localparam int ENC_WIDTH = 16;
   localparam int ENC_IDX_W = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } enc_state_t;

endpackage

// File: rtl/prio_enc16.sv
// Combinational priority encoder: pending vector -> index of the bit to emit next.
// Default picks the lowest set bit; with ENC_MSB_FIRST_EN defined it picks the highest.
module prio_enc16
   import enc_pkg::*;
#(
   parameter int WIDTH = ENC_WIDTH
) (
   input  logic [WIDTH-1:0]         i_vec,
   output logic [$clog2(WIDTH)-1:0] o_idx,
   output logic                     o_any
);

   localparam int IDX_W = $clog2(WIDTH);

   // NOTE: o_idx gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      o_idx = '0;
`ifdef ENC_MSB_FIRST_EN
      // Ascending walk: the last hit, i.e. the highest set bit, wins.
      for (int i = 0; i < WIDTH; i++) begin
         if (i_vec[i]) o_idx = IDX_W'(i);
      end
`else
      // Descending walk: the last hit, i.e. the lowest set bit, wins.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (i_vec[i]) o_idx = IDX_W'(i);
      end
`endif
   end

   assign o_any = |i_vec;

endmodule

// File: rtl/seq_encoder_16to4.sv
// Sequential encoder: accepts a multi-hot vector and streams the index of each set bit,
// one per handshake. ENC_MSB_FIRST_EN selects highest-first scanning instead of lowest-first.
module seq_encoder_16to4
   import enc_pkg::*;
#(
   parameter int WIDTH = ENC_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [WIDTH-1:0]         req,
   input  logic                     req_valid,
   output logic                     req_ready,
   output logic [$clog2(WIDTH)-1:0] idx,
   output logic                     idx_valid,
   input  logic                     idx_ready,
   output logic                     idx_last,
   output logic                     none
);

   localparam int IDX_W = $clog2(WIDTH);

   enc_state_t       r_state;
   enc_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_pend;
   logic [WIDTH-1:0] w_pend_nxt;
   logic             r_none;
   logic             w_none_nxt;
   logic             r_live;

   logic [IDX_W-1:0] w_idx;
   logic             w_any;
   logic             w_last;
   logic [WIDTH-1:0] w_pend_m1;
   logic [WIDTH-1:0] w_bit;
   logic             w_accept;
   logic             w_beat;

   prio_enc16 #(
      .WIDTH (WIDTH)
   ) u_prio (
      .i_vec (r_pend),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Exactly one bit set: clearing the lowest set bit leaves nothing behind.
   assign w_pend_m1 = r_pend - {{(WIDTH-1){1'b0}}, 1'b1};
   assign w_last    = w_any && ((r_pend & w_pend_m1) == '0);
   assign w_bit     = {{(WIDTH-1){1'b0}}, 1'b1} << w_idx;

   // r_live keeps req_ready low while reset is held and for the release edge.
   assign req_ready = r_live && (r_state == IDLE) && en;
   assign idx_valid = (r_state == SCAN) && en;
   assign idx       = w_idx;
   assign idx_last  = w_last;
   assign none      = r_none;

   assign w_accept  = req_valid && req_ready;
   assign w_beat    = idx_valid && idx_ready;

   // With en=0 neither handshake can fire, so state and pend hold by construction.
   always_comb begin
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend;
      w_none_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_pend_nxt = req;
               if (req == '0) begin
                  w_none_nxt = 1'b1;
               end else begin
                  w_state_nxt = SCAN;
               end
            end
         end
         SCAN: begin
            if (w_beat) begin
               if (w_last) begin
                  w_state_nxt = IDLE;
                  w_pend_nxt  = '0;
               end else begin
                  w_pend_nxt = r_pend & ~w_bit;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_pend_nxt  = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pend  <= '0;
         r_none  <= 1'b0;
         r_live  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_pend_nxt;
         r_none  <= w_none_nxt;
         r_live  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_encoder_16to4.sv
// Directed scoreboard bench for seq_encoder_16to4; expected index order follows ENC_MSB_FIRST_EN.
`timescale 1ns/1ps
module tb_seq_encoder_16to4;

`ifdef ENC_MSB_FIRST_EN
   localparam bit MSB_FIRST = 1'b1;
`else
   localparam bit MSB_FIRST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [15:0] req = '0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  idx;
   logic        idx_valid;
   logic        idx_ready = 1'b0;
   logic        idx_last;
   logic        none;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_none = 0;

   typedef struct {
      logic [3:0] idx;
      logic       last;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   seq_encoder_16to4 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .idx       (idx),
      .idx_valid (idx_valid),
      .idx_ready (idx_ready),
      .idx_last  (idx_last),
      .none      (none)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic push(input int i, input bit last);
      exp_t e;
      e.idx  = 4'(i);
      e.last = last;
      sb_q.push_back(e);
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [15:0] v);
      int n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) fail("send_ready_timeout");
      req       = v;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: every consumed beat is popped and compared; every none pulse must be expected.
   always @(negedge clk) begin
      if (idx_valid === 1'b1 && idx_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            fail("unexpected_idx_beat");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("idx", 32'(idx), 32'(e.idx));
            check("idx_last", 32'(idx_last), 32'(e.last));
         end
      end
      if (none === 1'b1) begin
         check("none_expected", 32'(exp_none > 0), 32'd1);
         if (exp_none > 0) exp_none--;
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with en high: nothing may be offered.
      en        = 1'b1;
      idx_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_idx_valid", 32'(idx_valid), 32'd0);
      check("rst_none", 32'(none), 32'd0);
      check("rst_idx", 32'(idx), 32'd0);
      check("rst_idx_last", 32'(idx_last), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Multi-bit vector, idx_ready held high.
      push(MSB_FIRST ? 5 : 0, 1'b0);
      push(3, 1'b0);
      push(MSB_FIRST ? 0 : 5, 1'b1);
      send(16'h0029);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("h0029_ready_after", 32'(req_ready), 32'd1);
      check("h0029_valid_after", 32'(idx_valid), 32'd0);
      check("h0029_sb_empty", 32'(sb_q.size()), 32'd0);

      // Backpressure: first index must hold for four cycles.
      @(posedge clk); #1;
      idx_ready = 1'b0;
      push(MSB_FIRST ? 15 : 0, 1'b0);
      push(MSB_FIRST ? 0 : 15, 1'b1);
      send(16'h8001);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(idx_valid), 32'd1);
         check("bp_idx_hold", 32'(idx), MSB_FIRST ? 32'd15 : 32'd0);
         check("bp_last_hold", 32'(idx_last), 32'd0);
      end
      @(posedge clk); #1;
      idx_ready = 1'b1;
      wait_drain(10);

      // All-zero vector: one none pulse, no index beats.
      exp_none = 1;
      send(16'h0000);
      @(negedge clk);
      check("zero_none_pulse", 32'(none), 32'd1);
      check("zero_no_valid", 32'(idx_valid), 32'd0);
      repeat (3) @(posedge clk); #1;
      check("zero_none_consumed", 32'(exp_none), 32'd0);
      check("zero_none_cleared", 32'(none), 32'd0);

      // en dropped after the seventh beat of a full vector.
      for (int i = 0; i < 16; i++) push(MSB_FIRST ? 15 - i : i, i == 15);
      send(16'hFFFF);
      repeat (7) @(posedge clk); #1;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("en0_valid", 32'(idx_valid), 32'd0);
         check("en0_ready", 32'(req_ready), 32'd0);
         check("en0_idx_frozen", 32'(idx), MSB_FIRST ? 32'd8 : 32'd7);
      end
      @(posedge clk); #1;
      en = 1'b1;
      wait_drain(30);

      // Asynchronous reset while the ninth-position index is on the bus.
      for (int i = 0; i < 9; i++) push(MSB_FIRST ? 15 - i : i, 1'b0);
      send(16'hFFFF);
      repeat (9) @(posedge clk); #1;
      check("pre_rst_idx", 32'(idx), MSB_FIRST ? 32'd6 : 32'd9);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(idx_valid), 32'd0);
      check("mid_rst_idx", 32'(idx), 32'd0);
      @(negedge clk);
      check("mid_rst_sb_empty", 32'(sb_q.size()), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      push(2, 1'b1);
      send(16'h0004);
      wait_drain(10);

      repeat (3) @(posedge clk); #1;
      check("final_sb_empty", 32'(sb_q.size()), 32'd0);
      check("final_none_empty", 32'(exp_none), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
